// File: rtl/prodsum_accum_pkg.sv
// Shared types and widths for the prodsum burst accumulator.
package prodsum_accum_pkg;

  localparam int unsigned CNT_W = 8;

  // One-hot encoding so that corrupted state values are detectable.
  typedef enum logic [1:0] {
    ACCUM = 2'b01,
    EMIT  = 2'b10
  } state_t;

endpackage

// File: rtl/prodsum_accum_sat.sv
// Combinational ACC_W + DATA_W adder with selectable wrap or clamp on carry-out.
module sat_add #(
  parameter int unsigned ACC_W  = 16,
  parameter int unsigned DATA_W = 8
) (
  input  logic [ACC_W-1:0]  a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic              sat_i,
  output logic [ACC_W-1:0]  sum_o,
  output logic              carry_o
);

  logic [ACC_W:0] full;

  always_comb begin
    full    = {1'b0, a_i} + (ACC_W+1)'(b_i);
    carry_o = full[ACC_W];
    sum_o   = (sat_i && carry_o) ? {ACC_W{1'b1}} : full[ACC_W-1:0];
  end

endmodule

// File: rtl/prodsum_accum.sv
// Sums bursts of prodsum beats and presents each total on a ready/valid result port.
module prodsum_accum
  import prodsum_accum_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ACC_W  = 16,
  parameter int unsigned COUNT  = 4,
  parameter bit          SAT    = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  output logic              in_ready_o,
  input  logic              in_valid_i,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic              flush_i,
  output logic [ACC_W-1:0]  acc_o,
  output logic [CNT_W-1:0]  acc_count_o,
  output logic              overflow_o,
  output logic              acc_valid_o,
  input  logic              acc_ready_i
);

  state_t             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovf_q, ovf_d;
  logic [CNT_W-1:0]   cnt_inc;
  logic [ACC_W-1:0]   sum;
  logic               carry;
  logic               beat;

  sat_add #(
    .ACC_W  (ACC_W),
    .DATA_W (DATA_W)
  ) u_sat_add (
    .a_i     (acc_q),
    .b_i     (in_data_i),
    .sat_i   (SAT),
    .sum_o   (sum),
    .carry_o (carry)
  );

  // Ready is a pure decode of state (and reset), never of in_valid_i.
  assign in_ready_o  = (state_q == ACCUM) && !rst_i;
  assign acc_valid_o = (state_q == EMIT);
  assign beat        = in_valid_i && in_ready_o;

  assign acc_o       = acc_q;
  assign acc_count_o = cnt_q;
  assign overflow_o  = ovf_q;

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    cnt_inc = cnt_q + CNT_W'(1);

    case (state_q)
      ACCUM: begin
        if (beat) begin
          acc_d = sum;
          cnt_d = cnt_inc;
          ovf_d = ovf_q | carry;
        end
        // An empty flush is dropped so no zero-beat result is ever emitted.
        if ((beat && (cnt_inc == CNT_W'(COUNT))) ||
            (flush_i && (beat || (cnt_q != '0)))) begin
          state_d = EMIT;
        end
      end
      EMIT: begin
        if (acc_ready_i) begin
          state_d = ACCUM;
          acc_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      default: begin
        state_d = ACCUM;
        acc_d   = '0;
        cnt_d   = '0;
        ovf_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ACCUM;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: tb/tb_prodsum_accum.sv
// Bench for prodsum_accum: directed table, hand sequences and random run against a burst-sum model.
module tb_prodsum_accum;

  localparam int unsigned COUNT = 4;

  logic        clk = 1'b0;
  logic        rst, v, fl, ack;
  logic [7:0]  d;

  logic        in_rdy16, val16, ovf16;
  logic [15:0] acc16;
  logic [7:0]  cnt16;
  logic        in_rdy8s, val8s, ovf8s;
  logic [7:0]  acc8s, cnt8s;
  logic        in_rdy8w, val8w, ovf8w;
  logic [7:0]  acc8w, cnt8w;

  int nchk = 0;
  int nerr = 0;

  int m_q[$];
  bit m_emit = 1'b0;

  always #5 clk = ~clk;

  prodsum_accum #(.DATA_W(8), .ACC_W(16), .COUNT(COUNT), .SAT(1'b1)) dut16 (
    .clk_i(clk), .rst_i(rst), .in_ready_o(in_rdy16), .in_valid_i(v), .in_data_i(d),
    .flush_i(fl), .acc_o(acc16), .acc_count_o(cnt16), .overflow_o(ovf16),
    .acc_valid_o(val16), .acc_ready_i(ack));

  prodsum_accum #(.DATA_W(8), .ACC_W(8), .COUNT(COUNT), .SAT(1'b1)) dut8s (
    .clk_i(clk), .rst_i(rst), .in_ready_o(in_rdy8s), .in_valid_i(v), .in_data_i(d),
    .flush_i(fl), .acc_o(acc8s), .acc_count_o(cnt8s), .overflow_o(ovf8s),
    .acc_valid_o(val8s), .acc_ready_i(ack));

  prodsum_accum #(.DATA_W(8), .ACC_W(8), .COUNT(COUNT), .SAT(1'b0)) dut8w (
    .clk_i(clk), .rst_i(rst), .in_ready_o(in_rdy8w), .in_valid_i(v), .in_data_i(d),
    .flush_i(fl), .acc_o(acc8w), .acc_count_o(cnt8w), .overflow_o(ovf8w),
    .acc_valid_o(val8w), .acc_ready_i(ack));

  task automatic chk(input string name, input logic [31:0] act, input longint exp);
    nchk++;
    if (act !== 32'(exp)) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Burst total from the list of accepted beats: clamp or modulo, overflow if it ever passed the max.
  function automatic longint exp_acc(input int w, input bit s);
    longint total = 0;
    longint lim   = longint'(1) << w;
    foreach (m_q[i]) total += m_q[i];
    if (total < lim) return total;
    return s ? lim - 1 : total % lim;
  endfunction

  function automatic bit exp_ovf(input int w);
    longint total = 0;
    foreach (m_q[i]) total += m_q[i];
    return total >= (longint'(1) << w);
  endfunction

  task automatic model_update(input bit r, input bit vv, input int dd, input bit ff, input bit rr);
    if (r) begin
      m_q.delete();
      m_emit = 1'b0;
    end else if (!m_emit) begin
      if (vv) m_q.push_back(dd);
      if ((m_q.size() == COUNT) || (ff && (m_q.size() > 0))) m_emit = 1'b1;
    end else if (rr) begin
      m_q.delete();
      m_emit = 1'b0;
    end
  endtask

  task automatic check_model();
    chk("mdl_val16", val16, m_emit);
    chk("mdl_acc16", acc16, exp_acc(16, 1'b1));
    chk("mdl_cnt16", cnt16, m_q.size());
    chk("mdl_ovf16", ovf16, exp_ovf(16));
    chk("mdl_val8s", val8s, m_emit);
    chk("mdl_acc8s", acc8s, exp_acc(8, 1'b1));
    chk("mdl_ovf8s", ovf8s, exp_ovf(8));
    chk("mdl_val8w", val8w, m_emit);
    chk("mdl_acc8w", acc8w, exp_acc(8, 1'b0));
    chk("mdl_cnt8w", cnt8w, m_q.size());
    chk("mdl_ovf8w", ovf8w, exp_ovf(8));
  endtask

  // One clock: drive at negedge, check ready before the edge, check results #1 after it.
  task automatic step(input bit r, input bit vv, input int dd, input bit ff, input bit rr);
    @(negedge clk);
    rst = r; v = vv; d = 8'(dd); fl = ff; ack = rr;
    #1;
    chk("pre_in_ready16", in_rdy16, !r && !m_emit);
    chk("pre_in_ready8w", in_rdy8w, !r && !m_emit);
    model_update(r, vv, dd, ff, rr);
    @(posedge clk);
    #1;
    check_model();
  endtask

  typedef struct {
    bit r; bit vv; int dd; bit ff; bit rr;
    bit e_val; bit e_rdy; int e_acc; int e_cnt; bit e_ovf;
  } vec_t;

  vec_t vecs[$];

  initial begin
    rst = 1'b1; v = 1'b0; d = '0; fl = 1'b0; ack = 1'b0;

    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    chk("reset_acc", acc16, 0);
    chk("reset_cnt", cnt16, 0);
    chk("reset_ovf", ovf16, 0);
    chk("reset_valid", val16, 0);
    chk("reset_in_ready", in_rdy16, 0);

    // Directed bursts: full burst, early flush, empty flush, flush with beat.
    vecs = '{
      '{0,1,10,0,1, 0,1, 10,1,0},
      '{0,1,20,0,1, 0,1, 30,2,0},
      '{0,1,30,0,1, 0,1, 60,3,0},
      '{0,1,40,0,1, 1,0,100,4,0},
      '{0,0, 0,0,1, 0,1,  0,0,0},
      '{0,1, 5,0,0, 0,1,  5,1,0},
      '{0,1, 7,0,0, 0,1, 12,2,0},
      '{0,0, 0,1,0, 1,0, 12,2,0},
      '{0,0, 0,0,1, 0,1,  0,0,0},
      '{0,0, 0,1,1, 0,1,  0,0,0},
      '{0,0, 0,0,1, 0,1,  0,0,0},
      '{0,1, 3,0,0, 0,1,  3,1,0},
      '{0,1, 4,1,0, 1,0,  7,2,0},
      '{0,0, 0,0,1, 0,1,  0,0,0}
    };
    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].r, vecs[i].vv, vecs[i].dd, vecs[i].ff, vecs[i].rr);
      chk($sformatf("vec%0d_valid", i), val16, vecs[i].e_val);
      chk($sformatf("vec%0d_in_ready", i), in_rdy16, vecs[i].e_rdy);
      chk($sformatf("vec%0d_acc", i), acc16, vecs[i].e_acc);
      chk($sformatf("vec%0d_cnt", i), cnt16, vecs[i].e_cnt);
      chk($sformatf("vec%0d_ovf", i), ovf16, vecs[i].e_ovf);
    end

    // Backpressure: result held 5 cycles while upstream keeps offering 9.
    step(0, 1, 1, 0, 0);
    step(0, 1, 2, 0, 0);
    step(0, 1, 3, 0, 0);
    step(0, 1, 4, 0, 0);
    for (int i = 0; i < 5; i++) begin
      step(0, 1, 9, 0, 0);
      chk("bp_acc_stable", acc16, 10);
      chk("bp_cnt_stable", cnt16, 4);
      chk("bp_valid", val16, 1);
      chk("bp_in_ready_low", in_rdy16, 0);
    end
    step(0, 1, 9, 0, 1);
    chk("bp_after_ack_acc", acc16, 0);
    chk("bp_after_ack_in_ready", in_rdy16, 1);
    step(0, 1, 9, 0, 0);
    chk("bp_nine_first_acc", acc16, 9);
    chk("bp_nine_first_cnt", cnt16, 1);
    step(0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 1);

    // Carry-out in 8-bit accumulators: clamp vs wrap.
    step(0, 1, 200, 0, 0);
    step(0, 1, 100, 0, 0);
    chk("sat_mid_acc8s", acc8s, 255);
    chk("wrap_mid_acc8w", acc8w, 44);
    step(0, 1, 1, 0, 0);
    step(0, 1, 1, 0, 0);
    chk("sat_acc8s", acc8s, 255);
    chk("sat_ovf8s", ovf8s, 1);
    chk("wrap_acc8w", acc8w, 46);
    chk("wrap_ovf8w", ovf8w, 1);
    chk("wide_acc16", acc16, 302);
    chk("wide_ovf16", ovf16, 0);
    step(0, 0, 0, 0, 1);
    chk("ovf_cleared8s", ovf8s, 0);

    // Reset mid-burst discards the partial sum.
    step(0, 1, 1, 0, 1);
    step(0, 1, 2, 0, 1);
    step(1, 1, 5, 0, 1);
    chk("rst_mid_acc", acc16, 0);
    chk("rst_mid_cnt", cnt16, 0);
    chk("rst_mid_in_ready", in_rdy16, 0);
    step(0, 0, 0, 0, 1);
    chk("rst_mid_no_valid", val16, 0);
    for (int i = 0; i < 4; i++) step(0, 1, 1, 0, 0);
    chk("post_rst_acc", acc16, 4);
    chk("post_rst_cnt", cnt16, 4);
    chk("post_rst_valid", val16, 1);
    step(0, 0, 0, 0, 1);

    // Randomised traffic checked against the burst-sum model.
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 99) < 2),
           ($urandom_range(0, 99) < 70),
           int'($urandom_range(0, 255)),
           ($urandom_range(0, 99) < 10),
           ($urandom_range(0, 99) < 60));
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
